// File: rtl/bus_master_if.sv
// bus_master_if: initiator engine for the shared single-master bus.
// Turns local single/burst read/write commands into request/grant bus cycles
// with incrementing, wrapping addresses. Read beats return on a valid-only stream.
//
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_wr, cmd_addr, cmd_len (beats-1)
//   wd_valid/wd_ready, wd_data  write beat stream
//   rd_valid, rd_data           read beat stream, one cycle per beat, no backpressure
//   done, err                   end-of-command pulse; err marks a grant timeout
//   m_req, m_wr, m_addr, m_dout bus master outputs
//   m_grant, m_din              bus grant and read data
module bus_master_if #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned LEN_W         = 8,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);

    localparam int unsigned TO_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StReq, StXfer, StDrain, StDone} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;     // beats still to issue, minus one
    logic                wr_q, wr_d;
    logic [TO_W-1:0]     to_q, to_d;
    // pipe_q[0] marks an address issued last edge; pipe_q[k] means its data is
    // on m_din k cycles after the address appeared on m_addr.
    logic [READ_LATENCY:0] pipe_q, pipe_d;
    logic                rd_issue;

    logic                m_req_d, m_wr_d, done_d, err_d, rd_valid_d;
    logic [ADDR_W-1:0]   m_addr_d;
    logic [DATA_W-1:0]   m_dout_d, rd_data_d;

    assign cmd_ready = (state_q == StIdle) && !reset;
    assign wd_ready  = (state_q == StXfer) && wr_q && m_grant;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wr_d     = wr_q;
        to_d     = to_q;
        m_wr_d   = 1'b0;
        m_addr_d = m_addr;
        m_dout_d = m_dout;
        err_d    = 1'b0;
        rd_issue = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    wr_d    = cmd_wr;
                    to_d    = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (m_grant) begin
                    state_d = StXfer;
                end else if (to_q + TO_W'(1) == TO_W'(GRANT_TIMEOUT)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StXfer: begin
                // Reads issue on every granted cycle; writes also need a data beat.
                if (m_grant && (!wr_q || wd_valid)) begin
                    m_addr_d = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                    if (wr_q) begin
                        m_wr_d   = 1'b1;
                        m_dout_d = wd_data;
                    end else begin
                        rd_issue = 1'b1;
                    end
                    if (len_q == '0) begin
                        state_d = StDrain;
                    end else begin
                        len_d = len_q - LEN_W'(1);
                    end
                end
            end
            StDrain: begin
                // Writes pass through in one cycle so the last m_wr pulse is seen
                // under m_req before done; reads wait for outstanding data.
                if (pipe_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        m_req_d    = (state_d == StReq) || (state_d == StXfer) || (state_d == StDrain);
        done_d     = (state_d == StDone);
        pipe_d     = {pipe_q[READ_LATENCY-1:0], rd_issue};
        rd_valid_d = pipe_q[READ_LATENCY];
        rd_data_d  = pipe_q[READ_LATENCY] ? m_din : rd_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            wr_q     <= 1'b0;
            to_q     <= '0;
            pipe_q   <= '0;
            m_req    <= 1'b0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_dout   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wr_q     <= wr_d;
            to_q     <= to_d;
            pipe_q   <= pipe_d;
            m_req    <= m_req_d;
            m_wr     <= m_wr_d;
            m_addr   <= m_addr_d;
            m_dout   <= m_dout_d;
            done     <= done_d;
            err      <= err_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed and randomized bench for bus_master_if.
// A latency-1 slave returns m_din = m_addr + 0x100. Observed bus writes, read beats
// and done pulses are collected and compared to expectations computed from the
// command (address + i wrapping at 2^16, write data in order, one done per command).
module tb_bus_master_if;

    localparam int GT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        done, err;
    logic        m_req, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din = '0;

    bus_master_if dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency-1 slave: data for the address seen in cycle c is on m_din in cycle c+1.
    always @(posedge clk) m_din <= 64'(m_addr) + 64'h100;

    // Stimulus driver: grant and write-data streams, applied 1 time unit after negedge.
    int          gmode = 1;      // 0 grant low, 1 manual, 2 random
    int          wmode = 0;      // 0 manual, 1 random
    logic        man_grant = 1'b0;
    logic        man_wd = 1'b0;
    logic        fire = 1'b0;
    logic [63:0] wq[$];

    always @(negedge clk) begin
        #1;
        if (fire && wq.size() > 0) wq.delete(0);
        case (gmode)
            0:       m_grant = 1'b0;
            1:       m_grant = man_grant;
            default: m_grant = m_req && ($urandom_range(0, 3) != 0);
        endcase
        wd_valid = (wq.size() > 0) && ((wmode == 0) ? man_wd : ($urandom_range(0, 2) != 0));
        wd_data  = (wq.size() > 0) ? wq[0] : 64'h0;
        #1 fire = wd_valid && wd_ready;
    end

    // Output collector, sampled 1 time unit after each rising edge.
    logic [79:0] obs_wr[$];
    logic [63:0] obs_rd[$];
    logic        obs_done[$];
    int          done_cyc = 0, last_wr_cyc = 0, last_rd_cyc = 0, req_rise_cyc = 0;
    logic        prev_req = 1'b0, prev_done = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (m_wr) begin
            obs_wr.push_back({m_addr, m_dout});
            last_wr_cyc = cyc;
            chk("wr_under_req", 128'(m_req), 128'(1));
        end
        if (rd_valid) begin
            obs_rd.push_back(rd_data);
            last_rd_cyc = cyc;
        end
        if (done) begin
            obs_done.push_back(err);
            done_cyc = cyc;
            chk("done_bus_quiet", 128'({m_req, m_wr}), 128'(0));
        end
        if (err) chk("err_with_done", 128'(done), 128'(1));
        if (m_req && !prev_req) req_rise_cyc = cyc;
        if (prev_done) chk("idle_after_done", 128'(m_req), 128'(0));
        if (prev_req && !m_req && !reset) chk("req_drops_only_at_done", 128'(done), 128'(1));
        prev_req  = m_req;
        prev_done = done;
    end

    logic [63:0] exp_wd[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_rd.delete();
        obs_done.delete();
        exp_wd.delete();
    endtask

    task automatic send_cmd(input logic wr, input logic [15:0] addr, input int len);
        int k = 0;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        chk("cmd_accept", 128'(cmd_ready), 128'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_wdata(input int n);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            wq.push_back(d);
            exp_wd.push_back(d);
        end
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (obs_done.size() == 0 && k < bound) begin
            tick();
            k++;
        end
        repeat (3) tick();
    endtask

    // Reference: beat i goes to (addr + i) mod 2^16; reads return that address + 0x100.
    task automatic check_cmd(input logic wr, input logic [15:0] addr, input int len);
        logic [15:0] a;
        if (wr) begin
            chk("wr_beats", 128'(obs_wr.size()), 128'(len + 1));
            chk("wr_no_rd", 128'(obs_rd.size()), 128'(0));
            for (int i = 0; i <= len && i < obs_wr.size(); i++) begin
                a = 16'((int'(addr) + i) % 65536);
                chk("wr_beat", 128'(obs_wr[i]), 128'({a, exp_wd[i]}));
            end
        end else begin
            chk("rd_beats", 128'(obs_rd.size()), 128'(len + 1));
            chk("rd_no_wr", 128'(obs_wr.size()), 128'(0));
            for (int i = 0; i <= len && i < obs_rd.size(); i++) begin
                a = 16'((int'(addr) + i) % 65536);
                chk("rd_beat", 128'(obs_rd[i]), 128'(64'(a) + 64'h100));
            end
        end
        chk("done_once", 128'(obs_done.size()), 128'(1));
        if (obs_done.size() > 0) chk("err_low", 128'(obs_done[0]), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] r_addr;
    logic        r_wr;
    int          r_len;
    int          k;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_ctrl", 128'({m_req, m_wr, rd_valid, done, err, cmd_ready, wd_ready}), 128'(0));
        chk("rst_data", 128'({m_addr, m_dout, rd_data}), 128'(0));
        reset = 1'b0;
        tick();
        chk("idle_ready", 128'(cmd_ready), 128'(1));

        // 1: single write, grant one cycle after m_req
        clear_obs();
        exp_wd.push_back(64'hABCD);
        wq.push_back(64'hABCD);
        man_wd    = 1'b1;
        man_grant = 1'b0;
        send_cmd(1'b1, 16'h0056, 0);
        chk("t1_req_up", 128'(m_req), 128'(1));
        man_grant = 1'b1;
        wait_done(50);
        check_cmd(1'b1, 16'h0056, 0);
        chk("t1_done_after_wr", 128'(done_cyc > last_wr_cyc), 128'(1));
        chk("t1_req_low", 128'(m_req), 128'(0));

        // 2: read burst of 4
        clear_obs();
        send_cmd(1'b0, 16'h7001, 3);
        wait_done(50);
        check_cmd(1'b0, 16'h7001, 3);
        chk("t2_done_after_rd", 128'(done_cyc > last_rd_cyc), 128'(1));

        // 3: write burst with data bubbles and a dropped grant
        clear_obs();
        push_wdata(4);
        send_cmd(1'b1, 16'h0200, 3);
        for (int j = 0; j < 10; j++) begin
            man_wd    = !(j == 3 || j == 4);
            man_grant = (j != 6);
            tick();
        end
        man_wd    = 1'b1;
        man_grant = 1'b1;
        wait_done(50);
        check_cmd(1'b1, 16'h0200, 3);

        // 4: grant never given -> timeout
        clear_obs();
        gmode = 0;
        send_cmd(1'b0, 16'h1234, 2);
        wait_done(100);
        chk("t4_done_once", 128'(obs_done.size()), 128'(1));
        if (obs_done.size() > 0) chk("t4_err", 128'(obs_done[0]), 128'(1));
        chk("t4_latency", 128'(done_cyc - req_rise_cyc), 128'(GT));
        chk("t4_no_beats", 128'(obs_rd.size() + obs_wr.size()), 128'(0));
        chk("t4_req_low", 128'(m_req), 128'(0));
        gmode = 1;

        // 5: read across address wrap
        clear_obs();
        send_cmd(1'b0, 16'hFFFF, 1);
        wait_done(50);
        check_cmd(1'b0, 16'hFFFF, 1);

        // 6: reset during beat 2 of an 8-beat write
        clear_obs();
        push_wdata(8);
        send_cmd(1'b1, 16'h3000, 7);
        k = 0;
        while (obs_wr.size() < 1 && k < 50) begin
            tick();
            k++;
        end
        chk("t6_beat1_seen", 128'(obs_wr.size()), 128'(1));
        reset = 1'b1;
        tick();
        chk("t6_rst_ctrl", 128'({m_req, m_wr, rd_valid, done, err, cmd_ready, wd_ready}),
            128'(0));
        chk("t6_rst_data", 128'({m_addr, m_dout, rd_data}), 128'(0));
        reset = 1'b0;
        wq.delete();
        clear_obs();
        repeat (5) tick();
        chk("t6_no_done", 128'(obs_done.size()), 128'(0));
        send_cmd(1'b0, 16'h4440, 5);
        wait_done(50);
        check_cmd(1'b0, 16'h4440, 5);

        // Randomized commands with random grant and write-data gaps
        gmode = 2;
        wmode = 1;
        for (int i = 0; i < 25; i++) begin
            clear_obs();
            wq.delete();
            r_wr   = 1'($urandom_range(0, 1));
            r_len  = $urandom_range(0, 12);
            r_addr = (i % 5 == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
            if (r_wr) push_wdata(r_len + 1);
            send_cmd(r_wr, r_addr, r_len);
            wait_done(2000);
            check_cmd(r_wr, r_addr, r_len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
